quarter_sine_dds: RTL

Parametrised direct digital synthesis (DDS) sine source. It is the successor to the 256-entry full-wave sine lookup.
- A phase accumulator with programmable frequency and phase offset drives a quarter-wave table, and the full wave is rebuilt by mirroring.
- Output is unsigned offset-binary samples with a valid strobe and a cycle-wrap marker.
- It sits between the control registers and the PWM/DAC pin driver.

---
 rtl/dds_pkg.sv | 70 +++++++
 rtl/quarter_sine_rom.sv | 42 ++++
 rtl/quarter_sine_dds.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/dds_pkg.sv
// -----------------------------------------------------------------------------
// dds_pkg
// Shared definitions for the quarter-wave DDS sine source.
//   quadrant_e     : which quarter of the full wave a phase index falls in
//   midpoint()     : offset-binary zero level for a given sample width
//   amplitude()    : peak table value for a given sample width
//   tableFileName(): name of the script-generated table image for a geometry
//   quarterSine()  : round(A * sin(2*pi*(k+0.5)/2^addrW)) in pure integer math
// -----------------------------------------------------------------------------
package dds_pkg;

   // Quadrant of the full wave, taken from the top two bits of the phase index.
   typedef enum logic [1:0] {
      Q_RISE  = 2'd0,
      Q_FALL  = 2'd1,
      Q_NRISE = 2'd2,
      Q_NFALL = 2'd3
   } quadrant_e;

   // pi with 60 fractional bits (hex expansion 3.243F6A8885A308D...).
   localparam logic [127:0] PI_Q60 = 128'h3243F6A8885A308D;

   // Taylor terms used by quarterSine; twelve terms leave the error far
   // below one part in 2^40 over the whole quarter wave.
   localparam int TAYLOR_TERMS = 12;

   // Offset-binary zero level: 2^(outW-1).
   function automatic logic [63:0] midpoint(input int outW);
      return 64'd1 << (outW - 1);
   endfunction

   // Peak table magnitude: 2^(outW-1) - 1, so the positive half never
   // overflows the sample word.
   function automatic logic [63:0] amplitude(input int outW);
      return (64'd1 << (outW - 1)) - 64'd1;
   endfunction

   // Name of the table image produced by the generator script.
   function automatic string tableFileName(input int addrW, input int outW);
      return $sformatf("quarter_sine_%0d_%0d.hex", addrW, outW);
   endfunction

   // One quarter-wave table entry, evaluated at elaboration time with
   // fixed-point arithmetic (60 fractional bits) so no real math reaches
   // the netlist. theta = pi*(2k+1)/2^addrW stays below pi/2, where every
   // partial sum of the sine series is positive, so unsigned math is safe.
   function automatic logic [63:0] quarterSine(input int k, input int addrW,
                                               input logic [63:0] ampl);
      logic [127:0] theta;
      logic [127:0] theta2;
      logic [127:0] term;
      logic [127:0] sum;
      logic [127:0] scaled;
      theta  = (PI_Q60 * 128'(2 * k + 1)) >> addrW;
      theta2 = (theta * theta) >> 60;
      term   = theta;
      sum    = theta;
      for (int n = 1; n <= TAYLOR_TERMS; n++) begin
         term = ((term * theta2) >> 60) / 128'((2 * n) * (2 * n + 1));
         if ((n % 2) == 1) begin
            sum = sum - term;
         end else begin
            sum = sum + term;
         end
      end
      scaled = ((128'(ampl) * sum) + (128'd1 << 59)) >> 60;
      return 64'(scaled);
   endfunction

endpackage

// File: rtl/quarter_sine_rom.sv
// -----------------------------------------------------------------------------
// quarter_sine_rom
// Quarter-wave sine table with a registered read port. Entry k holds
// round(A * sin(2*pi*(k+0.5)/2^(AW+2))) with A = 2^DW - 1.
// Ports:
//   i_clk  : clock, read address sampled on the rising edge
//   i_addr : table index k (already mirrored by the caller)
//   o_data : table value, valid one cycle after i_addr
// -----------------------------------------------------------------------------
module quarter_sine_rom
   import dds_pkg::*;
#(
   parameter int AW = 6,
   parameter int DW = 15
) (
   input  logic          i_clk,
   input  logic [AW-1:0] i_addr,
   output logic [DW-1:0] o_data
);

   localparam int         DEPTH = 1 << AW;
   localparam logic [63:0] AMPL = amplitude(DW + 1);

   logic [DW-1:0] w_table [DEPTH];
   logic [DW-1:0] r_data;

   // Every entry is a constant computed at elaboration, so the table folds
   // into a ROM without needing an external image file in the build.
   for (genvar g = 0; g < DEPTH; g++) begin : genEntry
      localparam logic [63:0] ENTRY = quarterSine(g, AW + 2, AMPL);
      assign w_table[g] = DW'(ENTRY);
   end

   // Registered read; no reset needed because the caller qualifies the
   // data with its own pipeline valid bit.
   always_ff @(posedge i_clk) begin
      r_data <= w_table[i_addr];
   end

   assign o_data = r_data;

endmodule

// File: rtl/quarter_sine_dds.sv
// -----------------------------------------------------------------------------
// quarter_sine_dds
// Direct digital synthesis sine source. A phase accumulator indexes a
// quarter-wave table; the full wave is rebuilt by mirroring the index and
// applying the sign around the offset-binary midpoint.
// Ports:
//   i_clk          : single clock, rising edge
//   i_reset        : synchronous, active-high
//   i_enable       : advance the accumulator and launch one sample
//   i_load         : capture i_freq_word and i_phase_offset
//   i_freq_word    : phase increment per enabled cycle
//   i_phase_offset : added to the accumulator before lookup
//   i_sync         : clear the accumulator, suppresses launch that edge
//   o_sample       : offset-binary sine sample (holds between valid cycles)
//   o_out_valid    : o_sample is new this cycle
//   o_wrap         : with o_out_valid, last sample before accumulator overflow
// Latency: a launch at edge t shows o_out_valid after edge t+2.
// -----------------------------------------------------------------------------
module quarter_sine_dds
   import dds_pkg::*;
#(
   parameter int PHASE_W = 24,
   parameter int ADDR_W  = 8,
   parameter int OUT_W   = 16
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_enable,
   input  logic               i_load,
   input  logic [PHASE_W-1:0] i_freq_word,
   input  logic [PHASE_W-1:0] i_phase_offset,
   input  logic               i_sync,
   output logic [OUT_W-1:0]   o_sample,
   output logic               o_out_valid,
   output logic               o_wrap
);

   localparam int               KW     = ADDR_W - 2;
   localparam int               QW     = OUT_W - 1;
   localparam logic [OUT_W-1:0] MID    = OUT_W'(midpoint(OUT_W));
   localparam logic [OUT_W-1:0] MID_M1 = MID - 1'b1;

   // Control registers and accumulator
   logic [PHASE_W-1:0] r_acc;
   logic [PHASE_W-1:0] r_freq;
   logic [PHASE_W-1:0] r_off;
   logic [PHASE_W-1:0] w_accNext;
   logic               w_carry;
   logic               w_launch;

   // Launch-side decode
   logic [ADDR_W-1:0]  w_idx;
   quadrant_e          w_quad;
   logic [KW-1:0]      w_kRaw;
   logic [KW-1:0]      w_kMirror;
   logic               w_neg;

   // Pipeline stages
   logic               r_s1Valid;
   logic               r_s1Neg;
   logic               r_s1Wrap;
   logic [KW-1:0]      r_s1K;
   logic               r_s2Valid;
   logic               r_s2Neg;
   logic               r_s2Wrap;
   logic [QW-1:0]      w_romData;
   logic [OUT_W-1:0]   w_posSample;
   logic [OUT_W-1:0]   w_negSample;
   logic [OUT_W-1:0]   r_sample;
   logic               r_outValid;
   logic               r_wrap;

   // The carry out of the accumulator add marks the final sample of a turn.
   assign {w_carry, w_accNext} = {1'b0, r_acc} + {1'b0, r_freq};

   // Sync wins over enable: the accumulator is being re-zeroed, so the
   // phase it currently holds is not a meaningful launch.
   assign w_launch = i_enable & ~i_sync;

   // Only the top ADDR_W bits of the offset phase select a table step.
   assign w_idx  = ADDR_W'((r_acc + r_off) >> (PHASE_W - ADDR_W));
   assign w_quad = quadrant_e'(w_idx[ADDR_W-1 -: 2]);
   assign w_kRaw = w_idx[KW-1:0];
   assign w_neg  = (w_quad == Q_NRISE) || (w_quad == Q_NFALL);

   // Falling quarters read the table backwards. Because entries sit at
   // half-step positions, ~k lands exactly on the mirrored point.
   always_comb begin
      w_kMirror = w_kRaw;
      unique case (w_quad)
         Q_RISE, Q_NRISE: w_kMirror = w_kRaw;
         Q_FALL, Q_NFALL: w_kMirror = ~w_kRaw;
      endcase
   end

   // Control registers and phase accumulator. load and sync are
   // independent, so both may take effect on the same edge.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_acc  <= '0;
         r_freq <= '0;
         r_off  <= '0;
      end else begin
         if (i_load) begin
            r_freq <= i_freq_word;
            r_off  <= i_phase_offset;
         end
         if (i_sync) begin
            r_acc <= '0;
         end else if (i_enable) begin
            r_acc <= w_accNext;
         end
      end
   end

   // Stage 1 captures the mirrored index, the half-wave sign and the wrap
   // flag; stage 2 carries sign/wrap alongside the registered table read.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_s1Valid <= 1'b0;
         r_s1Neg   <= 1'b0;
         r_s1Wrap  <= 1'b0;
         r_s1K     <= '0;
         r_s2Valid <= 1'b0;
         r_s2Neg   <= 1'b0;
         r_s2Wrap  <= 1'b0;
      end else begin
         r_s1Valid <= w_launch;
         r_s1Neg   <= w_neg;
         r_s1Wrap  <= w_carry;
         r_s1K     <= w_kMirror;
         r_s2Valid <= r_s1Valid;
         r_s2Neg   <= r_s1Neg;
         r_s2Wrap  <= r_s1Wrap;
      end
   end

   quarter_sine_rom #(
      .AW (KW),
      .DW (QW)
   ) uRom (
      .i_clk  (i_clk),
      .i_addr (r_s1K),
      .o_data (w_romData)
   );

   // Negative half sits one code below the midpoint so the two halves are
   // exact complements: pos + neg = 2^OUT_W - 1 for equal magnitudes.
   assign w_posSample = MID + OUT_W'(w_romData);
   assign w_negSample = MID_M1 - OUT_W'(w_romData);

   // Stage 3: apply sign. The sample register only updates on valid
   // cycles so the output holds through enable gaps.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_sample   <= MID;
         r_outValid <= 1'b0;
         r_wrap     <= 1'b0;
      end else begin
         r_outValid <= r_s2Valid;
         r_wrap     <= r_s2Valid & r_s2Wrap;
         if (r_s2Valid) begin
            r_sample <= r_s2Neg ? w_negSample : w_posSample;
         end
      end
   end

   assign o_sample    = r_sample;
   assign o_out_valid = r_outValid;
   assign o_wrap      = r_wrap;

endmodule
